// File: rtl/seq_divider.sv
// Restoring shift/subtract divider: one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN to add the signed_op port and signed (truncate-toward-zero) division.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ovfl
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  // The partial remainder is always below 2^(WIDTH-1) before a shift, so its MSB need not be stored.
  logic [WIDTH-2:0] prem_q, prem_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovp_q, ovp_d;

  logic             sop;
`ifdef SIGNED_DIV_EN
  assign sop = signed_op;
`else
  assign sop = 1'b0;
`endif

  logic             accept, last;
  logic [WIDTH-1:0] shifted, prem_nxt, qreg_nxt, dvd_mag, dvs_mag;
  logic [WIDTH:0]   trial;
  logic             step_bit, dvd_neg, dvs_neg;

  assign accept   = (state_q == S_IDLE) && start;
  assign last     = (state_q == S_CALC) && (cnt_q == CNT_W'(WIDTH - 1));
  assign shifted  = {prem_q, qreg_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {1'b0, dvsr_q};
  assign step_bit = ~trial[WIDTH];
  assign prem_nxt = step_bit ? trial[WIDTH-1:0] : shifted;
  assign qreg_nxt = {qreg_q[WIDTH-2:0], step_bit};
  assign dvd_neg  = sop & dividend[WIDTH-1];
  assign dvs_neg  = sop & divisor[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC:  if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    quotient  = quo_q;
    remainder = rem_q;
    div_zero  = dz_q;
    ovfl      = ov_q;
  end

  always_comb begin
    prem_d    = prem_q;
    qreg_d    = qreg_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ovp_d     = ovp_q;
    if (accept) begin
      dz_d = 1'b0;
      ov_d = 1'b0;
      if (divisor == '0) begin
        dz_d  = 1'b1;
        quo_d = '1;
        rem_d = dividend;
      end else begin
        prem_d    = '0;
        qreg_d    = dvd_mag;
        dvsr_d    = dvs_mag;
        cnt_d     = '0;
        neg_quo_d = dvd_neg ^ dvs_neg;
        neg_rem_d = dvd_neg;
        ovp_d     = sop && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
      end
    end else if (state_q == S_CALC) begin
      prem_d = prem_nxt[WIDTH-2:0];
      qreg_d = qreg_nxt;
      cnt_d  = cnt_q + CNT_W'(1);
      // Sign fix-up rides on the final step so signed latency matches unsigned.
      if (last) begin
        quo_d = neg_quo_q ? -qreg_nxt : qreg_nxt;
        rem_d = neg_rem_q ? -prem_nxt : prem_nxt;
        ov_d  = ovp_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prem_q    <= '0;
      qreg_q    <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovp_q     <= 1'b0;
    end else begin
      prem_q    <= prem_d;
      qreg_q    <= qreg_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ovp_q     <= ovp_d;
    end
  end

endmodule
